key_expansion_control: RTL and testbench
========================================

KEY_EXPANSION_CONTROL -- requirements
Module: key_expansion_control

Interface
REQ-001 SHALL declare ports in this positional order: rst, clk, input_key, output_key, output_key1, round.
REQ-002 rst  input  1  reset; one clock; reset is synchronous and active-low (rst=0 resets on the clk rising edge).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 input_key  input  8  cipher-key byte, one per cycle, most significant byte (key[127:120]) first.
REQ-005 output_key  output  8  registered round-key byte currently being streamed.
REQ-006 output_key1  output  128  registered last fully completed round key.
REQ-007 round  output  4  registered index (0..10) of the round key whose bytes appear on output_key.

Function
REQ-008 SHALL implement AES-128 key expansion (FIPS-197), byte-serial, one key byte per cycle.
REQ-009 SHALL use states LOAD, EXPAND, DONE; reset enters LOAD with byte counter cnt=0.
REQ-010 LOAD: each edge with rst=1, shift input_key into a 128-bit key register (new byte into LSB), drive output_key<=input_key, and increment cnt; this is edges 1..16 after reset release.
REQ-011 LOAD, cnt=15 edge: output_key1<=complete key K0; round stays 0; cnt wraps to 0; go to EXPAND.
REQ-012 EXPAND: round r (1..10) takes 16 edges; byte j (j=0..15) of Kr is computed and driven on output_key at edge j of that round.
REQ-013 Byte rule: Kr[j] = Kr-1[j] XOR t[j] for j<4, where t = SubWord(RotWord(last word of Kr-1)) XOR {Rcon[r],00,00,00}; Kr[j] = Kr-1[j] XOR Kr[j-4] for j>=4.
REQ-014 round SHALL increment to r at the edge producing byte 0 of Kr (edge 17 after reset release gives round=1).
REQ-015 At the edge producing byte 15 of Kr: output_key1<=Kr; if r=10, go to DONE.
REQ-016 DONE: all outputs hold (round=10, output_key1=K10, output_key=last byte of K10) until reset; input_key is ignored.
REQ-017 input_key is ignored outside LOAD.
REQ-018 Total latency: K0 on output_key1 after edge 16; K10 after edge 176.
REQ-019 Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
REQ-020 SubWord SHALL use the standard AES forward S-box, as combinational lookup.

Reset
REQ-021 On a rising edge with rst=0: output_key=8'h00, output_key1=128'h0, round=0, key register=0, cnt=0, state=LOAD.
REQ-022 Reset asserted mid-LOAD or mid-EXPAND SHALL abort and restart loading from the next byte after release; no partial state persists.

Structure
REQ-023 Shared package aes_pkg SHALL hold the state enum, the Rcon table, and the round count (10) and byte count (16) constants.
REQ-024 One sub-module aes_sbox (8-bit in, 8-bit out, combinational) SHALL be instantiated; the control FSM, counters and datapath stay in key_expansion_control.

Verification
REQ-025 Reset for 1 cycle, then stream key 2b7e151628aed2a6abf7158809cf4f3c MSB-first -> after edge 16 output_key1=2b7e151628aed2a6abf7158809cf4f3c and round=0.
REQ-026 Same key -> edge 17: round=1, output_key=A0; after edge 32: output_key1=a0fafe1788542cb123a339392a6c7605.
REQ-027 Same key -> after edge 176: output_key1=d014f9a8c9ee2589e13f0cc8b6630ca6, round=10; outputs unchanged 20 cycles later despite toggling input_key.
REQ-028 Key 000...0 -> K1=62636363626363636263636362636363, K10=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-029 Assert rst=0 at edge 50, release, reload the same key -> identical K1..K10 sequence and timing to REQ-026 and REQ-027.
REQ-030 Every edge during EXPAND: output_key equals the corresponding byte of the FIPS-197 reference schedule, and round changes only at byte 0 of each round.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared state encoding, round constants and sizes for AES-128 key expansion
package aes_pkg;

    typedef enum logic [1:0] {LOAD, EXPAND, DONE} state_t;

    localparam int NUM_ROUNDS = 10;
    localparam int NUM_BYTES  = 16;

    localparam logic [3:0] LAST_BYTE  = 4'(NUM_BYTES - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    // Indexed directly by round number; entries outside 1..10 are unused
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box lookup
module aes_sbox (
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_data = SBOX[i_data];

endmodule

// File: rtl/key_expansion_control.sv
// key_expansion_control: byte-serial AES-128 key expansion, one round-key byte per cycle
module key_expansion_control
    import aes_pkg::*;
(
    input  logic         rst,
    input  logic         clk,
    input  logic [7:0]   input_key,
    output logic [7:0]   output_key,
    output logic [127:0] output_key1,
    output logic [3:0]   round
);

    state_t           r_state, w_state_next;
    logic [3:0]       r_cnt;
    logic [15:0][7:0] r_key;
    logic [15:0][7:0] r_new;
    logic [1:0]       w_sidx;
    logic [7:0]       w_sub, w_rcon, w_byte;

    // Byte j of a key lives at array index 15-j; r_key holds the previous round key
    assign w_sidx = ~(r_cnt[1:0] + 2'd1);
    assign w_rcon = (r_cnt == 4'd0) ? RCON[round + 4'd1] : 8'h00;

    aes_sbox u_sbox (
        .i_data (r_key[{2'b00, w_sidx}]),
        .o_data (w_sub)
    );

    assign w_byte = (r_cnt[3:2] == 2'b00) ? (r_key[~r_cnt] ^ w_sub ^ w_rcon)
                                          : (r_key[~r_cnt] ^ r_new[3]);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= LOAD;
        else      r_state <= w_state_next;
    end

    // Next state: leave LOAD after 16 bytes, stop after the last byte of round 10
    always_comb begin
        w_state_next = r_state;
        if (r_state == LOAD && r_cnt == LAST_BYTE)
            w_state_next = EXPAND;
        else if (r_state == EXPAND && r_cnt == LAST_BYTE && round == LAST_ROUND)
            w_state_next = DONE;
    end

    // Datapath: shift in the cipher key, then build each round key one byte at a time
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= 4'd0;
            r_key       <= '0;
            r_new       <= '0;
            output_key  <= 8'h00;
            output_key1 <= '0;
            round       <= 4'd0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_key      <= {r_key[14:0], input_key};
                    output_key <= input_key;
                    r_cnt      <= r_cnt + 4'd1;
                    if (r_cnt == LAST_BYTE)
                        output_key1 <= {r_key[14:0], input_key};
                end
                EXPAND: begin
                    r_new      <= {r_new[14:0], w_byte};
                    output_key <= w_byte;
                    r_cnt      <= r_cnt + 4'd1;
                    if (r_cnt == 4'd0)
                        round <= round + 4'd1;
                    if (r_cnt == LAST_BYTE) begin
                        r_key       <= {r_new[14:0], w_byte};
                        output_key1 <= {r_new[14:0], w_byte};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_expansion_control.sv
// tb_key_expansion_control: directed check of byte-serial AES-128 key expansion
module tb_key_expansion_control;

    logic         rst = 1'b0;
    logic         clk = 1'b0;
    logic [7:0]   input_key = 8'h00;
    logic [7:0]   output_key;
    logic [127:0] output_key1;
    logic [3:0]   round;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KS [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] ZK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    key_expansion_control dut (
        .rst         (rst),
        .clk         (clk),
        .input_key   (input_key),
        .output_key  (output_key),
        .output_key1 (output_key1),
        .round       (round)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [7:0] b);
        @(negedge clk);
        input_key = b;
        @(posedge clk);
        #1;
    endtask

    // Reset one cycle, load key, expand all rounds, then verify outputs hold
    task automatic run_key(input logic [127:0] key, input bit full);
        logic [127:0] exp;
        logic [127:0] k10;
        k10 = full ? KS[10] : ZK10;
        rst = 1'b0;
        tick(8'hff);
        check("rst_okey", {120'd0, output_key}, 128'd0);
        check("rst_okey1", output_key1, 128'd0);
        check("rst_round", {124'd0, round}, 128'd0);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick(key[127-8*i -: 8]);
            check($sformatf("load_b%0d", i), {120'd0, output_key}, {120'd0, key[127-8*i -: 8]});
        end
        check("k0", output_key1, key);
        check("k0_round", {124'd0, round}, 128'd0);
        for (int r = 1; r <= 10; r++) begin
            for (int j = 0; j < 16; j++) begin
                tick(8'($urandom));
                if (full) begin
                    exp = KS[r];
                    check($sformatf("r%0d_b%0d", r, j), {120'd0, output_key}, {120'd0, exp[127-8*j -: 8]});
                end
                check($sformatf("r%0d_b%0d_round", r, j), {124'd0, round}, 128'(r));
            end
            if (full)
                check($sformatf("k%0d", r), output_key1, KS[r]);
            else if (r == 1)
                check("zk1", output_key1, ZK1);
            else if (r == 10)
                check("zk10", output_key1, ZK10);
        end
        for (int i = 0; i < 20; i++)
            tick(i[0] ? 8'h55 : 8'haa);
        check("hold_okey1", output_key1, k10);
        check("hold_round", {124'd0, round}, 128'd10);
        check("hold_okey", {120'd0, output_key}, {120'd0, k10[7:0]});
    endtask

    initial begin
        logic [127:0] kv;
        kv = KEY;
        run_key(KEY, 1'b1);
        run_key(128'd0, 1'b0);
        rst = 1'b0;
        tick(8'h00);
        rst = 1'b1;
        for (int i = 0; i < 49; i++)
            tick(i < 16 ? kv[127-8*i -: 8] : 8'($urandom));
        check("abort_round", {124'd0, round}, 128'd3);
        check("abort_k2", output_key1, KS[2]);
        run_key(KEY, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
